// File: rtl/pkt_rr_arbiter_if.sv
// Bundle of the four input FIFO read ports and the merged output port of
// pkt_rr_arbiter. master = arbiter side, slave = surrounding datapath.
interface pkt_rr_arbiter_if #(
  parameter int unsigned DATA_WIDTH = 64,
  parameter int unsigned CTRL_WIDTH = DATA_WIDTH / 8,
  parameter int unsigned NUM_INPUTS = 4
);
  localparam int unsigned GRANT_W = $clog2(NUM_INPUTS);

  logic [NUM_INPUTS-1:0]            in_fifo_vld;
  logic [NUM_INPUTS*DATA_WIDTH-1:0] in_fifo_data;
  logic [NUM_INPUTS*CTRL_WIDTH-1:0] in_fifo_ctrl;
  logic [NUM_INPUTS-1:0]            in_fifo_rd_en;
  logic                             out_wr;
  logic [DATA_WIDTH-1:0]            out_data;
  logic [CTRL_WIDTH-1:0]            out_ctrl;
  logic                             out_rdy;
  logic [GRANT_W-1:0]               cur_grant;
  logic                             pkt_sent;

  modport master (
    input  in_fifo_vld, in_fifo_data, in_fifo_ctrl, out_rdy,
    output in_fifo_rd_en, out_wr, out_data, out_ctrl, cur_grant, pkt_sent
  );

  modport slave (
    output in_fifo_vld, in_fifo_data, in_fifo_ctrl, out_rdy,
    input  in_fifo_rd_en, out_wr, out_data, out_ctrl, cur_grant, pkt_sent
  );
endinterface

// File: rtl/pkt_rr_arbiter.sv
// Packet-granular round-robin arbiter merging 4 fall-through FIFOs into one
// registered output stream. Packets never interleave.
// Optional build macro PKT_ARB_STRICT_PRIO_EN: input 0 gets absolute priority
// at each arbitration, inputs 1-3 share round-robin among themselves.
module pkt_rr_arbiter #(
  parameter int unsigned DATA_WIDTH = 64,
  parameter int unsigned CTRL_WIDTH = DATA_WIDTH / 8,
  parameter int unsigned NUM_INPUTS = 4
) (
  input logic              clk,
  input logic              reset,
  pkt_rr_arbiter_if.master bus
);
  localparam int unsigned GRANT_W = $clog2(NUM_INPUTS);

  localparam logic [1:0] ARB_IDLE     = 2'b01;
  localparam logic [1:0] ARB_MOVE_PKT = 2'b10;

  logic [1:0]            state_q, state_d;
  logic [GRANT_W-1:0]    grant_q, grant_d;
  logic [GRANT_W-1:0]    last_grant_q, last_grant_d;
  logic                  ctrl_prev_is_0_q;
  logic                  out_wr_q;
  logic [DATA_WIDTH-1:0] out_data_q;
  logic [CTRL_WIDTH-1:0] out_ctrl_q;

  logic [NUM_INPUTS-1:0] rd_en_c;
  logic                  pop_c;
  logic                  eop_c;
  logic                  grant_c;
  logic [GRANT_W-1:0]    pick_c;
  logic [NUM_INPUTS-1:0] cand_c;
  logic [GRANT_W-1:0]    scan_idx;
  logic [DATA_WIDTH-1:0] word_data_c;
  logic [CTRL_WIDTH-1:0] word_ctrl_c;

  // Head-of-FIFO word of the currently granted input.
  assign word_data_c = bus.in_fifo_data[32'(grant_q) * DATA_WIDTH +: DATA_WIDTH];
  assign word_ctrl_c = bus.in_fifo_ctrl[32'(grant_q) * CTRL_WIDTH +: CTRL_WIDTH];

  // Next winner: first valid input scanning last_grant+1 .. last_grant+N.
  always_comb begin
    cand_c   = bus.in_fifo_vld;
    pick_c   = last_grant_q;
    scan_idx = '0;
`ifdef PKT_ARB_STRICT_PRIO_EN
    cand_c[0] = 1'b0;
`endif
    // Descending scan so the nearest candidate is the one left standing.
    for (int k = int'(NUM_INPUTS); k >= 1; k--) begin
      scan_idx = GRANT_W'(last_grant_q + GRANT_W'(k));
      if (cand_c[scan_idx]) pick_c = scan_idx;
    end
`ifdef PKT_ARB_STRICT_PRIO_EN
    if (bus.in_fifo_vld[0]) pick_c = '0;
`endif
  end

  // Arbitration FSM: next state, grant bookkeeping and pop strobes.
  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    last_grant_d = last_grant_q;
    rd_en_c      = '0;
    pop_c        = 1'b0;
    eop_c        = 1'b0;
    grant_c      = 1'b0;
    case (state_q)
      ARB_IDLE: begin
        if (|bus.in_fifo_vld) begin
          grant_d = pick_c;
          grant_c = 1'b1;
          state_d = ARB_MOVE_PKT;
        end
      end
      ARB_MOVE_PKT: begin
        // A reset cycle never pops, so an aborted packet keeps its words.
        if (bus.out_rdy && bus.in_fifo_vld[grant_q] && !reset) begin
          pop_c            = 1'b1;
          rd_en_c[grant_q] = 1'b1;
          if ((word_ctrl_c != '0) && ctrl_prev_is_0_q) begin
            eop_c   = 1'b1;
            state_d = ARB_IDLE;
`ifdef PKT_ARB_STRICT_PRIO_EN
            if (grant_q != '0) last_grant_d = grant_q;
`else
            last_grant_d = grant_q;
`endif
          end
        end
      end
      default: state_d = ARB_IDLE;
    endcase
  end

  // State and grant registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ARB_IDLE;
      grant_q      <= '0;
      last_grant_q <= GRANT_W'(NUM_INPUTS - 1);
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
    end
  end

  // Output word register and EOP tracking of the previously popped ctrl.
  always_ff @(posedge clk) begin
    if (reset) begin
      out_wr_q         <= 1'b0;
      out_data_q       <= '0;
      out_ctrl_q       <= CTRL_WIDTH'(1);
      ctrl_prev_is_0_q <= 1'b0;
    end else begin
      out_wr_q <= pop_c;
      if (pop_c) begin
        out_data_q       <= word_data_c;
        out_ctrl_q       <= word_ctrl_c;
        ctrl_prev_is_0_q <= (word_ctrl_c == '0);
      end else if (grant_c) begin
        ctrl_prev_is_0_q <= 1'b0;
      end
    end
  end

  assign bus.in_fifo_rd_en = rd_en_c;
  assign bus.pkt_sent      = eop_c;
  assign bus.out_wr        = out_wr_q;
  assign bus.out_data      = out_data_q;
  assign bus.out_ctrl      = out_ctrl_q;
  assign bus.cur_grant     = grant_q;
endmodule

// File: tb/tb_pkt_rr_arbiter.sv
// Directed bench for pkt_rr_arbiter: per-input fall-through FIFO models,
// output/pop logs, and hand-derived expected streams and grant orders.
module tb_pkt_rr_arbiter;
  localparam int unsigned DW = 64;
  localparam int unsigned CW = 8;
  localparam int unsigned NI = 4;
  localparam int unsigned WW = CW + DW;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  pkt_rr_arbiter_if #(.DATA_WIDTH(DW), .CTRL_WIDTH(CW), .NUM_INPUTS(NI)) bus ();

  pkt_rr_arbiter #(.DATA_WIDTH(DW), .CTRL_WIDTH(CW), .NUM_INPUTS(NI)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int n_vec = 0;
  int n_err = 0;

  logic [WW-1:0] fq [NI][$];
  logic [NI-1:0] mask;
  logic [WW-1:0] out_log [$];
  int            src_log [$];
  int            sent_log [$];
  int            wr_cyc [$];
  int            n_sent;
  int            rdy_viol;
  int            cyc;
  logic [NI-1:0] last_rd;

  task automatic chk(input string tag, input logic [WW-1:0] obs, input logic [WW-1:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [WW-1:0] mkw(input logic [7:0] c, input int i, input int p, input int w);
    return {c, 32'hC0DE_5A5A, 8'(i), 8'(p), 8'(w), 8'h00};
  endfunction

  // Standard packet: n-1 words with ctrl 0, then an EOP word with ctrl 0x40|i.
  task automatic add_pkt(input int i, input int p, input int n);
    for (int w = 0; w < n; w++)
      fq[i].push_back(mkw((w == n - 1) ? (8'h40 | 8'(i)) : 8'h00, i, p, w));
  endtask

  task automatic drive();
    logic [NI-1:0]    v;
    logic [NI*DW-1:0] d;
    logic [NI*CW-1:0] c;
    logic [WW-1:0]    w;
    v = '0; d = '0; c = '0;
    for (int i = 0; i < int'(NI); i++) begin
      if (fq[i].size() != 0 && !mask[i]) begin
        w = fq[i][0];
        v[i] = 1'b1;
        d[i*DW +: DW] = w[DW-1:0];
        c[i*CW +: CW] = w[WW-1:DW];
      end
    end
    bus.in_fifo_vld  = v;
    bus.in_fifo_data = d;
    bus.in_fifo_ctrl = c;
  endtask

  // One clock: drive FIFO heads, observe pops, then observe registered outputs.
  task automatic step();
    logic [NI-1:0] rd;
    logic          snt;
    logic          rdy;
    drive();
    #1;
    rd = bus.in_fifo_rd_en;
    snt = bus.pkt_sent;
    rdy = bus.out_rdy;
    last_rd = rd;
    if (snt) n_sent++;
    for (int i = 0; i < int'(NI); i++)
      if (rd[i]) begin
        src_log.push_back(i);
        if (snt) sent_log.push_back(i);
      end
    @(posedge clk);
    #1;
    cyc++;
    for (int i = 0; i < int'(NI); i++)
      if (rd[i] && fq[i].size() != 0) void'(fq[i].pop_front());
    if (bus.out_wr) begin
      out_log.push_back({bus.out_ctrl, bus.out_data});
      wr_cyc.push_back(cyc);
      if (!rdy) rdy_viol++;
    end
  endtask

  task automatic clear_logs();
    out_log.delete(); src_log.delete(); sent_log.delete(); wr_cyc.delete();
    n_sent = 0; rdy_viol = 0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    mask = '0;
    bus.out_rdy = 1'b1;
    for (int i = 0; i < int'(NI); i++) fq[i].delete();
    drive();
    @(posedge clk);
    @(posedge clk);
    #1;
    reset = 1'b0;
    clear_logs();
  endtask

  function automatic int pending();
    int s;
    s = 0;
    for (int i = 0; i < int'(NI); i++) s += fq[i].size();
    return s;
  endfunction

  task automatic drain(input string tag, input int max);
    int c;
    c = 0;
    while (pending() != 0 && c < max) begin
      step();
      c++;
    end
    chk(tag, WW'(pending() == 0), WW'(1));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int exp_src [8];
    int exp_alt [4];
    cyc = 0;
    clear_logs();
    last_rd = '0;
    @(posedge clk);
    #1;

    // Reset values and idle behaviour with nothing valid.
    do_reset();
    chk("rst_out_wr",    WW'(bus.out_wr),        WW'(0));
    chk("rst_out_ctrl",  WW'(bus.out_ctrl),      WW'(1));
    chk("rst_out_data",  WW'(bus.out_data),      WW'(0));
    chk("rst_cur_grant", WW'(bus.cur_grant),     WW'(0));
    chk("rst_pkt_sent",  WW'(bus.pkt_sent),      WW'(0));
    chk("rst_rd_en",     WW'(bus.in_fifo_rd_en), WW'(0));
    step(); step();
    chk("idle_no_pop",   WW'(last_rd),           WW'(0));
    chk("idle_no_wr",    WW'(out_log.size()),    WW'(0));

    // Single 3-word packet on input 2 with a leading header word.
    do_reset();
    fq[2].push_back(mkw(8'hFF, 2, 0, 0));
    fq[2].push_back(mkw(8'h00, 2, 0, 1));
    fq[2].push_back(mkw(8'h10, 2, 0, 2));
    drain("t1_drain", 20);
    chk("t1_nwords",  WW'(out_log.size()), WW'(3));
    if (out_log.size() == 3) begin
      chk("t1_w0", out_log[0], mkw(8'hFF, 2, 0, 0));
      chk("t1_w1", out_log[1], mkw(8'h00, 2, 0, 1));
      chk("t1_w2", out_log[2], mkw(8'h10, 2, 0, 2));
      chk("t1_consecutive", WW'(wr_cyc[2] - wr_cyc[0]), WW'(2));
    end
    chk("t1_grant",   WW'(bus.cur_grant), WW'(2));
    chk("t1_nsent",   WW'(n_sent),        WW'(1));

    // All four inputs busy with two 2-word packets each: strict 0,1,2,3 rotation.
    do_reset();
    for (int p = 0; p < 2; p++)
      for (int i = 0; i < 4; i++) add_pkt(i, p, 2);
    drain("t2_drain", 100);
    chk("t2_nwords", WW'(out_log.size()), WW'(16));
    if (out_log.size() == 16)
      for (int k = 0; k < 16; k++)
        chk($sformatf("t2_word%0d", k), out_log[k],
            mkw((k % 2 == 1) ? (8'h40 | 8'((k / 2) % 4)) : 8'h00, (k / 2) % 4, k / 8, k % 2));
    chk("t2_nsent", WW'(sent_log.size()), WW'(8));
    if (sent_log.size() == 8)
      for (int s = 0; s < 8; s++)
        chk($sformatf("t2_order%0d", s), WW'(sent_log[s]), WW'(s % 4));

    // 10-word packet with out_rdy toggling every cycle.
    do_reset();
    add_pkt(1, 0, 10);
    begin
      int c;
      c = 0;
      while (pending() != 0 && c < 200) begin
        bus.out_rdy = (c % 2 == 0);
        step();
        c++;
      end
      bus.out_rdy = 1'b1;
      chk("t3_drain", WW'(pending() == 0), WW'(1));
    end
    chk("t3_nwords",   WW'(out_log.size()), WW'(10));
    chk("t3_rdy_viol", WW'(rdy_viol),       WW'(0));
    if (out_log.size() == 10)
      for (int w = 0; w < 10; w++)
        chk($sformatf("t3_word%0d", w), out_log[w], mkw((w == 9) ? 8'h41 : 8'h00, 1, 0, w));

    // Granted input stalls 3 cycles mid-packet while input 3 waits.
    do_reset();
    add_pkt(0, 0, 6);
    add_pkt(3, 0, 2);
    step(); step(); step();
    mask = 4'b0001;
    for (int g = 0; g < 3; g++) begin
      step();
      chk($sformatf("t4_gap_rd%0d", g),    WW'(last_rd),       WW'(0));
      chk($sformatf("t4_gap_grant%0d", g), WW'(bus.cur_grant), WW'(0));
    end
    mask = '0;
    drain("t4_drain", 50);
    exp_src = '{0, 0, 0, 0, 0, 0, 3, 3};
    chk("t4_npops", WW'(src_log.size()), WW'(8));
    if (src_log.size() == 8)
      for (int k = 0; k < 8; k++)
        chk($sformatf("t4_src%0d", k), WW'(src_log[k]), WW'(exp_src[k]));

    // Reset during the 4th word of a packet on input 1.
    do_reset();
    add_pkt(1, 0, 6);
    step(); step(); step(); step();
    reset = 1'b1;
    step();
    chk("t5_rst_no_pop",  WW'(last_rd),       WW'(0));
    chk("t5_rst_out_wr",  WW'(bus.out_wr),    WW'(0));
    chk("t5_rst_ctrl",    WW'(bus.out_ctrl),  WW'(1));
    chk("t5_rst_data",    WW'(bus.out_data),  WW'(0));
    chk("t5_rst_grant",   WW'(bus.cur_grant), WW'(0));
    chk("t5_left_words",  WW'(fq[1].size()),  WW'(3));
    reset = 1'b0;
    clear_logs();
    add_pkt(0, 0, 2);
    step();
    chk("t5_idle_after",  WW'(last_rd),       WW'(0));
    drain("t5_drain", 50);
    chk("t5_npops",       WW'(src_log.size()), WW'(5));
    if (src_log.size() == 5) begin
      chk("t5_first_src", WW'(src_log[0]), WW'(0));
      chk("t5_third_src", WW'(src_log[2]), WW'(1));
    end
    if (out_log.size() == 5)
      chk("t5_last_word", out_log[4], mkw(8'h41, 1, 0, 5));

    // Inputs 0 and 1 both busy: alternate, or input 0 always first under strict priority.
    do_reset();
    add_pkt(0, 0, 2); add_pkt(0, 1, 2);
    add_pkt(1, 0, 2); add_pkt(1, 1, 2);
    drain("t6_drain", 50);
`ifdef PKT_ARB_STRICT_PRIO_EN
    exp_alt = '{0, 0, 1, 1};
`else
    exp_alt = '{0, 1, 0, 1};
`endif
    chk("t6_nsent", WW'(sent_log.size()), WW'(4));
    if (sent_log.size() == 4)
      for (int s = 0; s < 4; s++)
        chk($sformatf("t6_order%0d", s), WW'(sent_log[s]), WW'(exp_alt[s]));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
